// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FSM controller, one shared ALU, one unified memory port with ready handshake.
// Optional build macro BNE_EN adds the bne opcode (0x05); without it bne traps as illegal.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retired,
  output logic              illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE  = 6'h05;
`endif

  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic        r_illegal;
  logic [31:0] r_regs [0:31];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_simm, w_rs_val, w_rt_val;
  logic [31:0] w_alu_a, w_alu_b, w_alu_y;
  logic [2:0]  w_alu_ctl, w_funct_ctl;
  logic        w_funct_ok, w_zero, w_take;
  logic        w_rf_we;
  logic [4:0]  w_rf_addr;
  logic [31:0] w_rf_dat;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_simm   = {{16{r_ir[15]}}, r_ir[15:0]};
  // $0 is hardwired: entry 0 is never written and never read
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_ctl = 3'b010;
    case (w_funct)
      6'h20:   w_funct_ctl = 3'b010;
      6'h22:   w_funct_ctl = 3'b110;
      6'h24:   w_funct_ctl = 3'b000;
      6'h25:   w_funct_ctl = 3'b001;
      6'h2A:   w_funct_ctl = 3'b111;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  // Operand steering for the single ALU; BRANCH reuses it as the A/B comparator.
  always_comb begin
    w_alu_a   = r_a;
    w_alu_b   = r_b;
    w_alu_ctl = 3'b010;
    case (r_state)
      S_FETCH:  begin w_alu_a = r_pc; w_alu_b = 32'd4; end
      S_DECODE: begin w_alu_a = r_pc; w_alu_b = w_simm << 2; end
      S_MEMADR, S_ADDIEX: w_alu_b = w_simm;
      S_EXEC:   w_alu_ctl = w_funct_ctl;
      S_BRANCH: w_alu_ctl = 3'b110;
      default:  ;
    endcase
  end

  always_comb begin
    case (w_alu_ctl)
      3'b110:  w_alu_y = w_alu_a - w_alu_b;
      3'b000:  w_alu_y = w_alu_a & w_alu_b;
      3'b001:  w_alu_y = w_alu_a | w_alu_b;
      3'b111:  w_alu_y = {31'd0, ($signed(w_alu_a) < $signed(w_alu_b))};
      default: w_alu_y = w_alu_a + w_alu_b;
    endcase
  end

  assign w_zero = (w_alu_y == 32'd0);
`ifdef BNE_EN
  assign w_take = (w_op == OP_BNE) ? !w_zero : w_zero;
`else
  assign w_take = w_zero;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = w_funct_ok ? S_EXEC : S_TRAP;
          OP_BEQ:       w_next = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       w_next = S_BRANCH;
`endif
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_addr = w_rt;
    w_rf_dat  = r_aluout;
    case (r_state)
      S_MEMWB:  begin w_rf_we = 1'b1; w_rf_dat = r_mdr; end
      S_ALUWB:  begin w_rf_we = 1'b1; w_rf_addr = w_rd; end
      S_ADDIWB: w_rf_we = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir <= mem_rdata;
          r_pc <= w_alu_y;
        end
        S_DECODE: begin
          r_a      <= w_rs_val;
          r_b      <= w_rt_val;
          r_aluout <= w_alu_y;
          if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
        S_MEMADR, S_EXEC, S_ADDIEX: r_aluout <= w_alu_y;
        S_MEMRD:  if (mem_ready) r_mdr <= mem_rdata;
        S_BRANCH: if (w_take) r_pc <= r_aluout;
        S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        default:  ;
      endcase
      if (w_rf_we && (w_rf_addr != 5'd0)) r_regs[w_rf_addr] <= w_rf_dat;
    end
  end

  // Address, data and write enable derive only from state and registers frozen during a wait.
  assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign mem_we    = (r_state == S_MEMWR);
  assign mem_addr  = (r_state == S_FETCH) ? r_pc[ADDR_W-1:0] : r_aluout[ADDR_W-1:0];
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign illegal   = r_illegal;
  assign retired   = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_ADDIWB) ||
                     (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                     ((r_state == S_MEMWR) && mem_ready);

endmodule
